// File: rtl/forward_scoreboard_unit_pkg.sv
// rtl/forward_scoreboard_unit_pkg.sv - shared types and constants for the forwarding/scoreboard unit
package forward_scoreboard_unit_pkg;

    localparam int NUM_REGS    = 32;
    localparam int REG_W       = 5;
    localparam int DEF_NUM_FWD = 2;
    localparam int DEF_LAT_W   = 3;

    // Select width needs one code per bypass stage plus the register-file code.
    function automatic int fsel_width(input int num_fwd);
        return $clog2(num_fwd + 1);
    endfunction

    localparam int DEF_FSEL_W = fsel_width(DEF_NUM_FWD);

    typedef logic [DEF_FSEL_W-1:0] fwd_sel_t;
    typedef logic [DEF_LAT_W-1:0]  lat_t;

    localparam int FWD_REGFILE = 0;

endpackage

// File: rtl/forward_scoreboard_unit_if.sv
// rtl/forward_scoreboard_unit_if.sv - decode-side issue, bypass-stage and hazard result signals
interface forward_scoreboard_unit_if #(
    parameter int NUM_SRC = 2,
    parameter int NUM_FWD = 2,
    parameter int LAT_W   = 3,
    parameter int PERF_W  = 16
);
    import forward_scoreboard_unit_pkg::*;

    localparam int FSEL_W = fsel_width(NUM_FWD);

    logic                       issue_valid;
    logic                       issue_regwrite;
    logic [REG_W-1:0]           issue_wsel;
    logic [LAT_W-1:0]           issue_lat;
    logic [NUM_SRC*REG_W-1:0]   issue_rsel;
    logic [NUM_FWD-1:0]         stage_regwrite;
    logic [NUM_FWD*REG_W-1:0]   stage_wsel;
    logic                       flush;
    logic                       stall;
    logic [NUM_SRC*FSEL_W-1:0]  forward;
    logic                       busy;
    logic [PERF_W-1:0]          stall_cycles;

    modport master (
        output issue_valid, issue_regwrite, issue_wsel, issue_lat, issue_rsel,
        output stage_regwrite, stage_wsel, flush,
        input  stall, forward, busy, stall_cycles
    );

    modport slave (
        input  issue_valid, issue_regwrite, issue_wsel, issue_lat, issue_rsel,
        input  stage_regwrite, stage_wsel, flush,
        output stall, forward, busy, stall_cycles
    );

endinterface

// File: rtl/forward_scoreboard_unit_fwd_select.sv
// rtl/forward_scoreboard_unit_fwd_select.sv - per-operand bypass priority encoder
module forward_scoreboard_unit_fwd_select
    import forward_scoreboard_unit_pkg::*;
#(
    parameter int NUM_FWD = 2,
    parameter int FSEL_W  = fsel_width(NUM_FWD)
) (
    input  logic [REG_W-1:0]         rsel_i,
    input  logic [NUM_FWD-1:0]       stage_regwrite_i,
    input  logic [NUM_FWD*REG_W-1:0] stage_wsel_i,
    output logic [FSEL_W-1:0]        sel_o
);

    // Scan oldest to youngest so the youngest matching stage is the last to write.
    always_comb begin
        sel_o = FSEL_W'(FWD_REGFILE);
        if (rsel_i != '0) begin
            for (int k = NUM_FWD - 1; k >= 0; k--) begin
                if (stage_regwrite_i[k] &&
                    stage_wsel_i[k*REG_W +: REG_W] == rsel_i &&
                    stage_wsel_i[k*REG_W +: REG_W] != '0) begin
                    sel_o = FSEL_W'(k + 1);
                end
            end
        end
    end

endmodule

// File: rtl/forward_scoreboard_unit.sv
// rtl/forward_scoreboard_unit.sv - bypass selects, multi-cycle producer scoreboard and issue stall
module forward_scoreboard_unit
    import forward_scoreboard_unit_pkg::*;
#(
    parameter int NUM_SRC = 2,
    parameter int NUM_FWD = 2,
    parameter int LAT_W   = 3,
    parameter int PERF_W  = 16
) (
    input  logic               CLK,
    input  logic               nRST,
    forward_scoreboard_unit_if.slave bus
);

    localparam int FSEL_W = fsel_width(NUM_FWD);

    logic [LAT_W-1:0]          cnt_q [NUM_REGS];
    logic [LAT_W-1:0]          cnt_d [NUM_REGS];
    logic [PERF_W-1:0]         stall_cycles_q;
    logic [PERF_W-1:0]         stall_cycles_d;
    logic [NUM_SRC*FSEL_W-1:0] fwd_sel;
    logic                      stall;
    logic                      accept;
    logic                      busy;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_fwd
        forward_scoreboard_unit_fwd_select #(
            .NUM_FWD (NUM_FWD),
            .FSEL_W  (FSEL_W)
        ) u_fwd_select (
            .rsel_i           (bus.issue_rsel[g*REG_W +: REG_W]),
            .stage_regwrite_i (bus.stage_regwrite),
            .stage_wsel_i     (bus.stage_wsel),
            .sel_o            (fwd_sel[g*FSEL_W +: FSEL_W])
        );
    end

    always_comb begin
        stall = 1'b0;
        if (bus.issue_valid && !bus.flush) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (bus.issue_rsel[i*REG_W +: REG_W] != '0 &&
                    cnt_q[bus.issue_rsel[i*REG_W +: REG_W]] != '0) begin
                    stall = 1'b1;
                end
            end
        end
    end

    assign accept = bus.issue_valid && !stall && !bus.flush &&
                    bus.issue_regwrite && bus.issue_wsel != '0;

    // Flush beats a fresh load, and a fresh load beats the countdown of its own entry.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            cnt_d[r] = cnt_q[r];
            if (bus.flush) begin
                cnt_d[r] = '0;
            end else if (accept && bus.issue_wsel == REG_W'(r)) begin
                cnt_d[r] = bus.issue_lat;
            end else if (cnt_q[r] != '0) begin
                cnt_d[r] = cnt_q[r] - LAT_W'(1);
            end
        end
        cnt_d[0] = '0;
    end

    always_comb begin
        busy = 1'b0;
        for (int r = 0; r < NUM_REGS; r++) begin
            busy = busy | (|cnt_q[r]);
        end
    end

    assign stall_cycles_d = (stall && !(&stall_cycles_q)) ? stall_cycles_q + PERF_W'(1)
                                                          : stall_cycles_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= '0;
            end
            stall_cycles_q <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign bus.stall        = stall;
    assign bus.forward      = fwd_sel;
    assign bus.busy         = busy;
    assign bus.stall_cycles = stall_cycles_q;

endmodule
